// File: rtl/imm_extend_pipe.sv
// Handshaked immediate-extension stage: extends a raw immediate (SEXT/ZEXT/UPPER/BRANCH)
// into a 2-entry FIFO. Optional zero-latency bypass when the `IMM_EXT_BYPASS_EN macro is defined.
`default_nettype none

module imm_extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [MODE_W-1:0] out_mode
);

    localparam logic [MODE_W-1:0] MODE_SEXT   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ZEXT   = 2'b01;
    localparam logic [MODE_W-1:0] MODE_UPPER  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BRANCH = 2'b11;

    function automatic logic [OUT_W-1:0] extend_imm(
        input logic [IN_W-1:0]   imm,
        input logic [MODE_W-1:0] mode
    );
        logic [OUT_W-1:0] sext_v;
        sext_v = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (mode)
            MODE_SEXT:   extend_imm = sext_v;
            MODE_ZEXT:   extend_imm = {{(OUT_W-IN_W){1'b0}}, imm};
            MODE_UPPER:  extend_imm = {imm, {(OUT_W-IN_W){1'b0}}};
            // IN_W <= OUT_W-2 guarantees the dropped top bits are sign copies
            MODE_BRANCH: extend_imm = {sext_v[OUT_W-3:0], 2'b00};
            default:     extend_imm = sext_v;
        endcase
    endfunction

    logic [1:0]        count_r;
    logic [OUT_W-1:0]  head_data_r;
    logic [MODE_W-1:0] head_mode_r;
    logic [OUT_W-1:0]  tail_data_r;
    logic [MODE_W-1:0] tail_mode_r;

    logic [OUT_W-1:0]  ext_s;
    logic              accept_s;
    logic              release_s;
    logic              pass_s;

    assign ext_s     = extend_imm(in_imm, in_mode);
    assign in_ready  = (count_r != 2'd2);
    assign accept_s  = in_valid & in_ready;
    assign release_s = out_valid & out_ready;

`ifdef IMM_EXT_BYPASS_EN
    logic bypass_s;

    // Present the incoming item directly when the buffer is empty
    always_comb begin
        bypass_s = (count_r == 2'd0) & in_valid & ~flush & ~rst;
        pass_s   = bypass_s & out_ready;
        if (bypass_s) begin
            out_valid = 1'b1;
            out_data  = ext_s;
            out_mode  = in_mode;
        end else begin
            out_valid = (count_r != 2'd0);
            out_data  = head_data_r;
            out_mode  = head_mode_r;
        end
    end
`else
    assign pass_s    = 1'b0;
    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_data_r;
    assign out_mode  = head_mode_r;
`endif

    // FIFO occupancy and entry storage; flush wins over accept/release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= 2'd0;
            head_data_r <= {OUT_W{1'b0}};
            head_mode_r <= {MODE_W{1'b0}};
            tail_data_r <= {OUT_W{1'b0}};
            tail_mode_r <= {MODE_W{1'b0}};
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (accept_s && !pass_s) begin
                        head_data_r <= ext_s;
                        head_mode_r <= in_mode;
                        count_r     <= 2'd1;
                    end else begin
                        count_r <= 2'd0;
                    end
                end
                2'd1: begin
                    if (accept_s && release_s) begin
                        head_data_r <= ext_s;
                        head_mode_r <= in_mode;
                        count_r     <= 2'd1;
                    end else if (accept_s) begin
                        tail_data_r <= ext_s;
                        tail_mode_r <= in_mode;
                        count_r     <= 2'd2;
                    end else if (release_s) begin
                        count_r <= 2'd0;
                    end else begin
                        count_r <= 2'd1;
                    end
                end
                2'd2: begin
                    if (release_s) begin
                        head_data_r <= tail_data_r;
                        head_mode_r <= tail_mode_r;
                        count_r     <= 2'd1;
                    end else begin
                        count_r <= 2'd2;
                    end
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (16->32 instance plus a 12->32 instance).
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;

    logic        v12_in_valid;
    logic        v12_in_ready;
    logic [11:0] v12_in_imm;
    logic [1:0]  v12_in_mode;
    logic        v12_out_valid;
    logic [31:0] v12_out_data;
    logic [1:0]  v12_out_mode;

    int n_checks;
    int n_errors;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .MODE_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(32), .MODE_W(2)) dut12 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(v12_in_valid), .in_ready(v12_in_ready), .in_imm(v12_in_imm), .in_mode(v12_in_mode),
        .out_valid(v12_out_valid), .out_ready(1'b1), .out_data(v12_out_data), .out_mode(v12_out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One isolated transfer with out_ready=1: 1-cycle latency, then released
    task automatic send_one(input string tag, input logic [15:0] imm, input logic [1:0] mode,
                            input logic [31:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, out_data, exp);
        check_eq({tag, "_mode"}, 32'(out_mode), 32'(mode));
        @(posedge clk);
        #1;
        check_eq({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    // Push one SEXT item at the next edge with whatever out_ready is set
    task automatic push(input logic [15:0] imm);
        @(negedge clk);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_imm       = 16'h0000;
        in_mode      = 2'b00;
        out_ready    = 1'b1;
        v12_in_valid = 1'b0;
        v12_in_imm   = 12'h000;
        v12_in_mode  = 2'b00;

        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_data", out_data, 32'h0000_0000);
        check_eq("rst_out_mode", 32'(out_mode), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Extension modes
        send_one("sext", 16'h8001, 2'b00, 32'hFFFF_8001);
        send_one("zext", 16'h8001, 2'b01, 32'h0000_8001);
        send_one("upper", 16'h1234, 2'b10, 32'h1234_0000);
        send_one("br_neg", 16'hFFFF, 2'b11, 32'hFFFF_FFFC);
        send_one("br_pos", 16'h0004, 2'b11, 32'h0000_0010);

        // Back-pressure: A,B fill the buffer, C is held off
        out_ready = 1'b0;
        push(16'h0001);
        push(16'h0002);
        @(negedge clk);
        in_valid = 1'b1;
        in_imm   = 16'h0003;
        check_eq("bp_full_ready", 32'(in_ready), 32'd0);
        check_eq("bp_head_hold", out_data, 32'h0000_0001);
        @(negedge clk);
        check_eq("bp_still_full", 32'(in_ready), 32'd0);
        check_eq("bp_head_hold2", out_data, 32'h0000_0001);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_out_b", out_data, 32'h0000_0002);
        check_eq("bp_valid_b", 32'(out_valid), 32'd1);
        @(negedge clk);
        check_eq("bp_ready_c", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("bp_out_c", out_data, 32'h0000_0003);
        check_eq("bp_valid_c", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        check_eq("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: one result per cycle, count stays 1
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_imm   = 16'h0010 + 16'(i);
            in_mode  = 2'b00;
            check_eq("stream_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            check_eq("stream_data", out_data, 32'h0000_0010 + 32'(i));
            check_eq("stream_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("stream_empty", 32'(out_valid), 32'd0);

        // Flush with a full buffer and a concurrent offer
        out_ready = 1'b0;
        push(16'h0055);
        push(16'h0066);
        @(negedge clk);
        check_eq("fl_full", 32'(in_ready), 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_imm   = 16'h0077;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_valid", 32'(out_valid), 32'd0);
        check_eq("fl_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_eq("fl_no_ghost", 32'(out_valid), 32'd0);
        send_one("fl_after", 16'h0099, 2'b01, 32'h0000_0099);

        // Asynchronous reset between edges with a full buffer
        out_ready = 1'b0;
        push(16'h00AA);
        push(16'h00BB);
        @(negedge clk);
        check_eq("ar_full", 32'(in_ready), 32'd0);
        check_eq("ar_valid_pre", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", 32'(out_valid), 32'd0);
        check_eq("ar_ready", 32'(in_ready), 32'd1);
        check_eq("ar_data", out_data, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ar_no_spurious", 32'(out_valid), 32'd0);
        send_one("ar_first", 16'h0005, 2'b00, 32'h0000_0005);

        // 12-bit instance
        @(negedge clk);
        v12_in_valid = 1'b1;
        v12_in_imm   = 12'h800;
        v12_in_mode  = 2'b00;
`ifdef IMM_EXT_BYPASS_EN
        #1;
        check_eq("w12_bypass_valid", 32'(v12_out_valid), 32'd1);
        check_eq("w12_sext", v12_out_data, 32'hFFFF_F800);
`else
        check_eq("w12_no_bypass", 32'(v12_out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_eq("w12_sext", v12_out_data, 32'hFFFF_F800);
`endif
        @(negedge clk);
        v12_in_imm  = 12'h7FF;
        v12_in_mode = 2'b11;
`ifdef IMM_EXT_BYPASS_EN
        #1;
        check_eq("w12_branch", v12_out_data, 32'h0000_1FFC);
`else
        @(posedge clk);
        #1;
        check_eq("w12_branch", v12_out_data, 32'h0000_1FFC);
        check_eq("w12_branch_mode", 32'(v12_out_mode), 32'd3);
`endif
        v12_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("w12_empty", 32'(v12_out_valid), 32'd0);
        check_eq("w12_ready", 32'(v12_in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, handshaked immediate-extension stage for the decode path. It accepts a raw instruction immediate plus an extension mode. It produces the full-width operand through a 2-entry buffer, so decode stalls do not drop or duplicate immediates. It generalises plain 16→32 sign extension to selectable widths and four extension modes, with flow control and flush.

Parameters:
IN_W, 16, width of raw immediate; legal range 1..OUT_W-2
OUT_W, 32, width of extended operand
MODE_W, 2, width of mode field (fixed encoding below; do not change)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous; discards all buffered entries
in_valid  in  1  producer has immediate
in_ready  out  1  stage can accept
in_imm  in  IN_W  raw immediate
in_mode  in  MODE_W  00 SEXT, 01 ZEXT, 10 UPPER, 11 BRANCH
out_valid  out  1  out_data holds a result
out_ready  in  1  consumer accepts
out_data  out  OUT_W  extended operand
out_mode  out  MODE_W  mode used for out_data

Behaviour:
- Reset: one clock, rst asynchronous active-high. While rst is asserted: count=0, out_valid=0, in_ready=1, out_data=0, out_mode=0, both entries cleared.
- Extension (computed at accept, stored extended):
  - SEXT: {(OUT_W-IN_W){imm[IN_W-1]}, imm}
  - ZEXT: {(OUT_W-IN_W){0}, imm}
  - UPPER: {imm, (OUT_W-IN_W){0}}
  - BRANCH: SEXT value shifted left 2, low 2 bits 0; top bits dropped (sign preserved because OUT_W≥IN_W+2)
- Buffer: 2-entry FIFO, entry0 = head.
  - count in {0,1,2}.
  - in_ready = (count<2), registered-derived, not a function of out_ready.
  - out_valid = (count>0).
  - out_data/out_mode driven from head.
- Accept: in_valid & in_ready. Release: out_valid & out_ready.
- Latency: 1 cycle. A value accepted at edge N is visible on out_data after edge N when the buffer was empty.
- Simultaneous accept+release:
  - count=1: head replaced by new item, count stays 1.
  - count=2: no accept is possible.
- Release at count=2: entry1 moves to head, count=1.
- Ordering: strict FIFO, no reordering or duplication.
- out_data holds its value while out_valid & !out_ready.
- Outputs with count=0: out_data/out_mode hold their last value; do not care to consumer.
- flush: at the next edge count=0, out_valid=0, in_ready=1. An accept or release in the same cycle is ignored. flush has priority over everything except rst.
- rst mid-transfer: buffered items are lost; no spurious out_valid after release of rst.
- in_mode X or illegal values are not checked; all 4 encodings are legal.

Optional Feature:
IMM_EXT_BYPASS_EN
- Defined: when count=0 and in_valid, out_valid=1 and out_data/out_mode = the combinational extension of in_imm/in_mode in the same cycle (zero latency).
  - If out_ready is also 1, the item is consumed without being stored and count stays 0.
  - If out_ready=0, the item is stored as normal.
  - Creates a combinational path in_*→out_*.
- Undefined: no bypass; always 1-cycle latency. All outputs are purely from registers.

Test Plan:
- IN_W=16, OUT_W=32, out_ready=1, in_valid pulse:
  - SEXT 0x8001 → out_data=0xFFFF8001 one cycle later.
  - ZEXT 0x8001 → 0x00008001.
  - UPPER 0x1234 → 0x12340000.
  - BRANCH 0xFFFF → 0xFFFFFFFC; BRANCH 0x0004 → 0x00000010.
- Back-pressure: out_ready=0, offer A=0x0001, B=0x0002, C=0x0003 (SEXT) back-to-back → A,B accepted, in_ready=0 while C held. Raise out_ready → outputs 0x1,0x2,0x3 in order, no gaps once C accepted.
- Streaming: in_valid=out_ready=1 for 8 cycles, incrementing immediates → count stays 1, one result per cycle, in_ready never drops.
- Flush: count=2 and flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, count=0. Flushed items never appear on out_data.
- Async reset: assert rst between clock edges with count=2 → out_valid=0 and in_ready=1 immediately, before the next edge. After rst release, the first accepted item appears with 1-cycle latency.
- Parameter sweep: IN_W=12, OUT_W=32, SEXT 0x800 → 0xFFFFF800; BRANCH 0x7FF → 0x00001FFC. With IMM_EXT_BYPASS_EN, the first item appears in the accept cycle.
